barry_sprite_render: RTL and testbench

Consumer end of Barry's vertical-position interface. Takes the y0 position driven by the jetpack position block, plus the raw thrust input, and turns them into per-pixel sprite and flame coverage for the VGA pixel pipeline. It latches position once per frame so the sprite does not tear. It also checks Barry's pixels against the obstacle renderer's pixels and reports collisions to game control.

---
 rtl/barry_pkg.sv | 15 +
 rtl/barry_collide.sv | 57 +++++
 rtl/barry_sprite_render.sv | 105 ++++++++++
 tb/tb_barry_sprite_render.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/barry_pkg.sv
// Shared constants and types for Barry's sprite renderer and its helpers.
package barry_pkg;

  localparam int SCREEN_W      = 640;
  localparam int SCREEN_H      = 480;
  localparam int BARRY_Y_RESET = 469;
  localparam int BARRY_Y_MIN   = 4;
  localparam int BARRY_Y_MAX   = 470;

  typedef enum logic {
    WAIT_FRAME = 1'b0,
    DRAW       = 1'b1
  } render_state_e;

endpackage

// File: rtl/barry_collide.sv
// Collision bookkeeping: a per-frame collision flag, a one-cycle frame_hit
// pulse at each frame boundary, and a sticky hit flag with a clear input.
module barry_collide
  import barry_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic frame_start,
  input  logic active,
  input  logic in_b,
  input  logic obstacle_px,
  input  logic hit_clear,
  output logic frame_hit,
  output logic hit
);

  logic coll_flag_q, coll_flag_d;
  logic frame_hit_q, frame_hit_d;
  logic hit_q, hit_d;

  // Next-state: collect collisions within a frame, report and reset them at the boundary.
  always_comb begin
    coll_flag_d = coll_flag_q;
    frame_hit_d = 1'b0;
    hit_d       = hit_q;
    if (frame_start) begin
      // coll_flag can only be set while drawing, so the first boundary never pulses.
      frame_hit_d = coll_flag_q;
      coll_flag_d = 1'b0;
    end else if (active && in_b && obstacle_px) begin
      coll_flag_d = 1'b1;
    end
    // A boundary that reports a collision overrides a simultaneous clear.
    if (frame_start && coll_flag_q) begin
      hit_d = 1'b1;
    end else if (hit_clear) begin
      hit_d = 1'b0;
    end
  end

  // State registers with asynchronous reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      coll_flag_q <= 1'b0;
      frame_hit_q <= 1'b0;
      hit_q       <= 1'b0;
    end else begin
      coll_flag_q <= coll_flag_d;
      frame_hit_q <= frame_hit_d;
      hit_q       <= hit_d;
    end
  end

  assign frame_hit = frame_hit_q;
  assign hit       = hit_q;

endmodule

// File: rtl/barry_sprite_render.sv
// Barry sprite renderer: latches position/thrust once per frame, produces
// registered sprite and flame coverage for the scan position, and forwards
// sprite coverage to the collision tracker.
module barry_sprite_render
  import barry_pkg::*;
#(
  parameter int X0      = 64,
  parameter int W       = 16,
  parameter int H       = 10,
  parameter int FLAME_W = 6,
  parameter int FLICKER = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [8:0] y0,
  input  logic       thrust,
  input  logic [9:0] x,
  input  logic [8:0] y,
  input  logic       frame_start,
  input  logic       obstacle_px,
  input  logic       hit_clear,
  output logic       barry_px,
  output logic       flame_px,
  output logic       frame_hit,
  output logic       hit
);

  localparam int FCW = (FLICKER > 1) ? $clog2(FLICKER) : 1;

  // Column bounds in 11 bits so no sum or difference wraps.
  localparam logic [10:0] B_X_LO = 11'(X0);
  localparam logic [10:0] B_X_HI = 11'(X0 + W - 1);
  localparam logic [10:0] F_X_LO = 11'((X0 >= FLAME_W) ? (X0 - FLAME_W) : 0);
  localparam logic [10:0] F_X_HI = 11'((X0 > 0) ? (X0 - 1) : 0);
  // No flame column exists when the sprite sits at column 0; no flame row when H < 5.
  localparam bit          F_EN   = (X0 > 0) && (FLAME_W > 0) && (H >= 5);
  localparam logic [9:0]  B_ROWS = 10'(H - 1);
  localparam logic [9:0]  F_ROWS = 10'((H >= 5) ? (H - 3) : 2);
  localparam logic [FCW-1:0] FLICK_ON = FCW'(FLICKER / 2);

  render_state_e  state_q;
  logic [8:0]     y_lat_q;
  logic           thr_lat_q;
  logic [FCW-1:0] flick_cnt_q;
  logic           barry_px_q;
  logic           flame_px_q;

  logic           active;
  logic           in_b;
  logic           in_f;
  logic [10:0]    x_ext;
  logic [9:0]     row;
  logic [9:0]     row_top;

  assign active = (state_q == DRAW) && !frame_start;

  // Coverage test for the current scan position; rows are compared in 10 bits.
  always_comb begin
    x_ext   = {1'b0, x};
    row     = {1'b0, y};
    row_top = {1'b0, y_lat_q};
    in_b    = (x_ext >= B_X_LO) && (x_ext <= B_X_HI) &&
              (row >= row_top) && (row <= row_top + B_ROWS);
    in_f    = F_EN && thr_lat_q && (flick_cnt_q < FLICK_ON) &&
              (x_ext >= F_X_LO) && (x_ext <= F_X_HI) &&
              (row >= row_top + 10'd2) && (row <= row_top + F_ROWS);
  end

  // Render FSM: frame latches, flicker counter and registered pixel outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= WAIT_FRAME;
      y_lat_q     <= 9'(BARRY_Y_RESET);
      thr_lat_q   <= 1'b0;
      flick_cnt_q <= '0;
      barry_px_q  <= 1'b0;
      flame_px_q  <= 1'b0;
    end else begin
      barry_px_q <= active && in_b;
      flame_px_q <= active && in_f;
      if (frame_start) begin
        state_q     <= DRAW;
        y_lat_q     <= y0;
        thr_lat_q   <= thrust;
        flick_cnt_q <= flick_cnt_q + FCW'(1);
      end
    end
  end

  assign barry_px = barry_px_q;
  assign flame_px = flame_px_q;

  barry_collide u_collide (
    .clk        (clk),
    .reset      (reset),
    .frame_start(frame_start),
    .active     (active),
    .in_b       (in_b),
    .obstacle_px(obstacle_px),
    .hit_clear  (hit_clear),
    .frame_hit  (frame_hit),
    .hit        (hit)
  );

endmodule

// File: tb/tb_barry_sprite_render.sv
// Self-checking bench for barry_sprite_render against a frame-level model.
module tb_barry_sprite_render;

  localparam int X0      = 64;
  localparam int W       = 16;
  localparam int H       = 10;
  localparam int FLAME_W = 6;
  localparam int FLICKER = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic [8:0] y0;
  logic       thrust;
  logic [9:0] x;
  logic [8:0] y;
  logic       frame_start;
  logic       obstacle_px;
  logic       hit_clear;
  logic       barry_px;
  logic       flame_px;
  logic       frame_hit;
  logic       hit;

  int checks = 0;
  int errors = 0;

  // Reference model state
  bit m_draw;
  int m_ylat;
  bit m_thr;
  int m_frames;
  bit m_coll;
  bit m_hit;
  bit exp_b, exp_f, exp_fh, exp_hit;

  always #5 clk = ~clk;

  barry_sprite_render #(
    .X0(X0), .W(W), .H(H), .FLAME_W(FLAME_W), .FLICKER(FLICKER)
  ) dut (
    .clk(clk), .reset(reset), .y0(y0), .thrust(thrust), .x(x), .y(y),
    .frame_start(frame_start), .obstacle_px(obstacle_px), .hit_clear(hit_clear),
    .barry_px(barry_px), .flame_px(flame_px), .frame_hit(frame_hit), .hit(hit)
  );

  function automatic bit mdl_in_b(input int px, input int py);
    return (px >= X0) && (px < X0 + W) && (py >= m_ylat) && (py < m_ylat + H);
  endfunction

  function automatic bit mdl_in_f(input int px, input int py);
    int lo;
    lo = (X0 >= FLAME_W) ? X0 - FLAME_W : 0;
    return m_thr && ((m_frames % FLICKER) < FLICKER / 2) &&
           (px >= lo) && (px < X0) && (py >= m_ylat + 2) && (py <= m_ylat + H - 3);
  endfunction

  task automatic model_reset();
    m_draw = 0; m_ylat = 469; m_thr = 0; m_frames = 0; m_coll = 0; m_hit = 0;
  endtask

  // Drive one cycle of inputs, advance the model, and wait until outputs settle.
  task automatic tick(input int tx, input int ty, input bit fs, input bit obs,
                      input bit clr, input int ny0, input bit nthr);
    bit act, ib;
    x = 10'(tx); y = 9'(ty); frame_start = fs; obstacle_px = obs;
    hit_clear = clr; y0 = 9'(ny0); thrust = nthr;
    act    = m_draw && !fs;
    ib     = mdl_in_b(tx, ty);
    exp_b  = act && ib;
    exp_f  = act && mdl_in_f(tx, ty);
    exp_fh = fs && m_coll;
    if (fs && m_coll) m_hit = 1;
    else if (clr) m_hit = 0;
    exp_hit = m_hit;
    if (fs) begin
      m_coll = 0; m_ylat = ny0; m_thr = nthr; m_frames++; m_draw = 1;
    end else if (act && ib && obs) begin
      m_coll = 1;
    end
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    reset = 1; x = 0; y = 0; frame_start = 0; obstacle_px = 0; hit_clear = 0;
    y0 = 9'd469; thrust = 0;
    repeat (2) @(posedge clk);
    #1 reset = 0;
    model_reset();
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (barry_px !== 1'b0) begin errors++; $display("FAIL reset_barry got=%b want=0", barry_px); end
    checks++; if (flame_px !== 1'b0) begin errors++; $display("FAIL reset_flame got=%b want=0", flame_px); end
    checks++; if (frame_hit !== 1'b0) begin errors++; $display("FAIL reset_frame_hit got=%b want=0", frame_hit); end
    checks++; if (hit !== 1'b0) begin errors++; $display("FAIL reset_hit got=%b want=0", hit); end
    // Sprite region at the reset row must stay dark before the first frame_start.
    for (int cx = 60; cx <= 85; cx++) begin
      tick(cx, 470, 0, 1, 0, 100, 1);
      checks++; if (barry_px !== 1'b0) begin errors++; $display("FAIL wait_barry x=%0d got=%b want=0", cx, barry_px); end
    end
    $display("test_reset done: checks=%0d errors=%0d", checks, errors);
  endtask

  task automatic test_basic();
    int rows [3] = '{100, 109, 110};
    tick(0, 0, 1, 0, 0, 100, 0);
    for (int r = 0; r < 3; r++) begin
      for (int cx = 60; cx <= 85; cx++) begin
        tick(cx, rows[r], 0, 0, 0, 0, 0);
        checks++;
        if (barry_px !== exp_b) begin
          errors++; $display("FAIL basic_barry x=%0d y=%0d got=%b want=%b", cx, rows[r], barry_px, exp_b);
        end
        checks++;
        if (flame_px !== exp_f) begin
          errors++; $display("FAIL basic_flame x=%0d y=%0d got=%b want=%b", cx, rows[r], flame_px, exp_f);
        end
      end
    end
    $display("test_basic done: checks=%0d errors=%0d", checks, errors);
  endtask

  task automatic test_move();
    int rows [6] = '{100, 105, 199, 200, 209, 210};
    // y0 changes mid-frame: sprite must not move yet.
    for (int r = 0; r < 6; r++) begin
      tick(70, rows[r], 0, 0, 0, 200, 0);
      checks++;
      if (barry_px !== exp_b) begin
        errors++; $display("FAIL move_pre y=%0d got=%b want=%b", rows[r], barry_px, exp_b);
      end
    end
    tick(0, 0, 1, 0, 0, 200, 0);
    for (int r = 0; r < 6; r++) begin
      tick(70, rows[r], 0, 0, 0, 100, 0);
      checks++;
      if (barry_px !== exp_b) begin
        errors++; $display("FAIL move_post y=%0d got=%b want=%b", rows[r], barry_px, exp_b);
      end
    end
    $display("test_move done: checks=%0d errors=%0d", checks, errors);
  endtask

  task automatic test_flame();
    for (int f = 0; f < 8; f++) begin
      tick(0, 0, 1, 0, 0, 150, (f < 6));
      for (int ry = 150; ry <= 159; ry++) begin
        for (int cx = 55; cx <= 66; cx++) begin
          tick(cx, ry, 0, 0, 0, 0, 0);
          checks++;
          if (flame_px !== exp_f) begin
            errors++; $display("FAIL flame frame=%0d x=%0d y=%0d got=%b want=%b", f, cx, ry, flame_px, exp_f);
          end
          checks++;
          if (barry_px !== exp_b) begin
            errors++; $display("FAIL flame_barry frame=%0d x=%0d y=%0d got=%b want=%b", f, cx, ry, barry_px, exp_b);
          end
        end
      end
    end
    $display("test_flame done: checks=%0d errors=%0d", checks, errors);
  endtask

  task automatic test_collision();
    tick(0, 0, 1, 0, 0, 300, 1);
    tick(70, 303, 0, 1, 0, 0, 0);
    tick(80, 303, 0, 1, 0, 0, 0);
    tick(10, 10, 0, 0, 0, 0, 0);
    tick(0, 0, 1, 0, 0, 300, 1);
    checks++; if (frame_hit !== exp_fh || exp_fh !== 1'b1) begin errors++; $display("FAIL coll_pulse got=%b want=%b", frame_hit, exp_fh); end
    checks++; if (hit !== exp_hit) begin errors++; $display("FAIL coll_hit got=%b want=%b", hit, exp_hit); end
    tick(10, 10, 0, 0, 0, 0, 0);
    checks++; if (frame_hit !== exp_fh) begin errors++; $display("FAIL coll_pulse_len got=%b want=%b", frame_hit, exp_fh); end
    checks++; if (hit !== exp_hit) begin errors++; $display("FAIL coll_sticky got=%b want=%b", hit, exp_hit); end
    // Flame-only pixels never collide, whatever the flicker phase.
    for (int cx = 58; cx <= 63; cx++) tick(cx, 303, 0, 1, 0, 0, 0);
    tick(0, 0, 1, 0, 0, 300, 1);
    checks++; if (frame_hit !== exp_fh) begin errors++; $display("FAIL flame_nohit got=%b want=%b", frame_hit, exp_fh); end
    checks++; if (hit !== exp_hit) begin errors++; $display("FAIL flame_hit_keep got=%b want=%b", hit, exp_hit); end
    $display("test_collision done: checks=%0d errors=%0d", checks, errors);
  endtask

  task automatic test_hit_clear();
    tick(64, 300, 0, 1, 0, 0, 0);
    tick(0, 0, 1, 0, 1, 300, 0);
    checks++; if (hit !== exp_hit) begin errors++; $display("FAIL clear_vs_set got=%b want=%b", hit, exp_hit); end
    checks++; if (frame_hit !== exp_fh) begin errors++; $display("FAIL clear_vs_set_pulse got=%b want=%b", frame_hit, exp_fh); end
    tick(10, 10, 0, 0, 1, 0, 0);
    checks++; if (hit !== exp_hit) begin errors++; $display("FAIL clear_alone got=%b want=%b", hit, exp_hit); end
    tick(10, 10, 0, 0, 0, 0, 0);
    checks++; if (hit !== exp_hit) begin errors++; $display("FAIL clear_stays got=%b want=%b", hit, exp_hit); end
    // Set again, then a clear on a collision-free boundary must clear.
    tick(65, 301, 0, 1, 0, 0, 0);
    tick(0, 0, 1, 0, 0, 300, 0);
    checks++; if (hit !== exp_hit) begin errors++; $display("FAIL reset_hit_again got=%b want=%b", hit, exp_hit); end
    tick(0, 0, 1, 0, 1, 300, 0);
    checks++; if (hit !== exp_hit) begin errors++; $display("FAIL clear_on_quiet_frame got=%b want=%b", hit, exp_hit); end
    $display("test_hit_clear done: checks=%0d errors=%0d", checks, errors);
  endtask

  task automatic test_edges();
    int tops [2] = '{470, 511};
    for (int t = 0; t < 2; t++) begin
      tick(0, 0, 1, 0, 0, tops[t], 0);
      for (int ry = 0; ry <= 511; ry++) begin
        if (ry <= 12 || ry >= 466) begin
          tick(70, ry, 0, 0, 0, 0, 0);
          checks++;
          if (barry_px !== exp_b) begin
            errors++; $display("FAIL edge top=%0d y=%0d got=%b want=%b", tops[t], ry, barry_px, exp_b);
          end
        end
      end
    end
    $display("test_edges done: checks=%0d errors=%0d", checks, errors);
  endtask

  task automatic test_async_reset();
    tick(0, 0, 1, 0, 0, 50, 1);
    tick(70, 52, 0, 1, 0, 0, 0);
    tick(0, 0, 1, 0, 0, 50, 1);
    tick(70, 52, 0, 0, 0, 0, 0);
    checks++; if (barry_px !== exp_b || exp_b !== 1'b1) begin errors++; $display("FAIL pre_reset_barry got=%b want=%b", barry_px, exp_b); end
    checks++; if (hit !== 1'b1) begin errors++; $display("FAIL pre_reset_hit got=%b want=1", hit); end
    // Mid-cycle reset must drop everything without waiting for an edge.
    reset = 1;
    #2;
    checks++; if (barry_px !== 1'b0) begin errors++; $display("FAIL async_barry got=%b want=0", barry_px); end
    checks++; if (hit !== 1'b0) begin errors++; $display("FAIL async_hit got=%b want=0", hit); end
    checks++; if (flame_px !== 1'b0 || frame_hit !== 1'b0) begin errors++; $display("FAIL async_other flame=%b frame_hit=%b want=0", flame_px, frame_hit); end
    @(posedge clk); #1 reset = 0;
    model_reset();
    for (int cx = 60; cx <= 85; cx++) begin
      tick(cx, 52, 0, 0, 0, 50, 1);
      checks++; if (barry_px !== exp_b) begin errors++; $display("FAIL post_reset_dark x=%0d got=%b want=%b", cx, barry_px, exp_b); end
    end
    tick(0, 0, 1, 0, 0, 50, 1);
    tick(70, 52, 0, 0, 0, 0, 0);
    checks++; if (barry_px !== exp_b) begin errors++; $display("FAIL post_reset_draw got=%b want=%b", barry_px, exp_b); end
    $display("test_async_reset done: checks=%0d errors=%0d", checks, errors);
  endtask

  task automatic test_random();
    int tx, ty, lo, hi, ny0;
    bit fs, obs, clr, thr;
    for (int i = 0; i < 3000; i++) begin
      fs  = ($urandom_range(0, 149) == 0);
      obs = ($urandom_range(0, 7) == 0);
      clr = ($urandom_range(0, 59) == 0);
      thr = $urandom_range(0, 1);
      ny0 = ($urandom_range(0, 9) == 0) ? 511 : $urandom_range(4, 470);
      tx  = $urandom_range(50, 90);
      lo  = (m_ylat - 2 < 0) ? 0 : m_ylat - 2;
      hi  = (m_ylat + 11 > 511) ? 511 : m_ylat + 11;
      ty  = $urandom_range(lo, hi);
      tick(tx, ty, fs, obs, clr, ny0, thr);
      checks++; if (barry_px !== exp_b) begin errors++; $display("FAIL rnd_barry i=%0d x=%0d y=%0d got=%b want=%b", i, tx, ty, barry_px, exp_b); end
      checks++; if (flame_px !== exp_f) begin errors++; $display("FAIL rnd_flame i=%0d x=%0d y=%0d got=%b want=%b", i, tx, ty, flame_px, exp_f); end
      checks++; if (frame_hit !== exp_fh) begin errors++; $display("FAIL rnd_frame_hit i=%0d got=%b want=%b", i, frame_hit, exp_fh); end
      checks++; if (hit !== exp_hit) begin errors++; $display("FAIL rnd_hit i=%0d got=%b want=%b", i, hit, exp_hit); end
    end
    $display("test_random done: checks=%0d errors=%0d", checks, errors);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_move();
    test_flame();
    test_collision();
    test_hit_clear();
    test_edges();
    test_async_reset();
    do_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
